// File: rtl/mem_burst_pkg.sv
// Shared types for the memory burst sequencer: FSM state encoding and a
// small constant helper used to size the shared down-counter.
package mem_burst_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    WAIT = 3'd2,
    XFER = 3'd3,
    DONE = 3'd4
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mem_burst_fsm.sv
// Memory-access sequencer: one rd/wr command strobe, WAIT_CYC wait states,
// then a ready-stalled burst of data strobes with an incrementing address.
module mem_burst_fsm
  import mem_burst_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int LEN_W    = 4,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic              we,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              ready,
  input  logic              abort,
  output logic              rd,
  output logic              wr,
  output logic              ds,
  output logic [ADDR_W-1:0] addr_o,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int               CNT_W     = max_int(LEN_W, $clog2(WAIT_CYC + 1));
  localparam bit               HAS_WAIT  = (WAIT_CYC > 0);
  localparam logic [CNT_W-1:0] WAIT_LOAD = HAS_WAIT ? CNT_W'(WAIT_CYC - 1) : '0;

  state_e           state;
  logic             we_q;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       rst_sync;
  logic             rst_core_n;

  // NOTE: reset asserts asynchronously but releases only after two clock
  // edges, so every flop leaves reset on the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_core_n = rst_sync[1];

  // NOTE: all state and outputs use non-blocking assignments so every output
  // is decoded from the next state and updates on the same edge as the state.
  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state  <= IDLE;
      we_q   <= 1'b0;
      len_q  <= '0;
      cnt    <= '0;
      addr_o <= '0;
      rd     <= 1'b0;
      wr     <= 1'b0;
      ds     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      rd   <= 1'b0;
      wr   <= 1'b0;
      ds   <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      busy <= 1'b1;

      case (state)
        IDLE: begin
          if (go) begin
            state  <= CMD;
            we_q   <= we;
            len_q  <= len;
            addr_o <= addr_i;
            rd     <= !we;
            wr     <= we;
          end else begin
            busy <= 1'b0;
          end
        end

        CMD: begin
          if (abort) begin
            state <= DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end else if (HAS_WAIT) begin
            state <= WAIT;
            cnt   <= WAIT_LOAD;
          end else begin
            state <= XFER;
            cnt   <= CNT_W'(len_q);
            ds    <= 1'b1;
          end
        end

        WAIT: begin
          if (abort) begin
            state <= DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end else if (cnt == '0) begin
            state <= XFER;
            cnt   <= CNT_W'(len_q);
            ds    <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        XFER: begin
          // ds is always high here, so ready alone marks a completed beat.
          if (ready) addr_o <= addr_o + ADDR_W'(1);
          if (abort) begin
            state <= DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end else if (ready && cnt == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            ds <= 1'b1;
            if (ready) cnt <= cnt - CNT_W'(1);
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_burst_fsm.md
# mem_burst_fsm

Parametrised memory-access sequencer with registered, glitch-free outputs. On a `go` request it issues one read or write command strobe, waits a configurable number of wait states, then runs a burst of data strobes with an incrementing address, stalling on memory `ready`. It sits between a requesting master and an asynchronous-style memory port that needs clean `rd`/`wr`/`ds` strobes.

## Interface
- `ADDR_W`, 16: address width.
- `LEN_W`, 4: width of burst-length field; bursts are 1..2^LEN_W beats.
- `WAIT_CYC`, 2: wait states between command and first data strobe; 0 skips WAIT.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `go`  in  1  start request; sampled only in IDLE.
- `we`  in  1  1 = write burst, 0 = read burst; sampled with `go`.
- `len`  in  LEN_W  beats minus one; sampled with `go`.
- `addr_i`  in  ADDR_W  start address; sampled with `go`.
- `ready`  in  1  memory accepts/presents a beat this cycle.
- `abort`  in  1  terminate current operation.
- `rd`  out  1  read command strobe (registered).
- `wr`  out  1  write command strobe (registered).
- `ds`  out  1  data strobe (registered).
- `addr_o`  out  ADDR_W  current beat address (registered).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  qualifies `done`: 1 = aborted.

## Operation
- States: IDLE, CMD, WAIT, XFER, DONE.
- IDLE: `go`=1 latches `we`, `len`, `addr_i` and goes to CMD; otherwise stays in IDLE.
- CMD: one cycle; `rd`=!we_q, `wr`=we_q. Goes to WAIT if WAIT_CYC>0, else to XFER.
- WAIT: exactly WAIT_CYC cycles, then XFER.
- XFER: `ds`=1 throughout. A beat completes on a cycle with `ds`=1 and `ready`=1; `addr_o` then increments by 1, wrapping modulo 2^ADDR_W. After beat len_q+1 completes, goes to DONE. `ready`=0 holds state, `ds`, and `addr_o`.
- DONE: one cycle; `done`=1, `err`=abort flag. Always returns to IDLE; `go` in DONE is ignored.
- `abort`=1 in CMD, WAIT, or XFER goes to DONE next edge with `err`=1. A beat completing in the same cycle still increments `addr_o`. `abort` is ignored in IDLE and DONE.
- `go` is ignored outside IDLE. No queuing.
- Unreachable state encodings go to IDLE.
- All outputs come from next-state decode, registered, so they change only on clock edges and align with the state register.
- Reset, at any time including mid-burst: state IDLE; `rd`, `wr`, `ds`, `busy`, `done`, `err` = 0; `addr_o` = 0. Asynchronous assert, synchronous release.

## Timing
- `go` sampled at edge E0: `rd` or `wr` high E0→E1.
- First `ds` at E(1+WAIT_CYC).
- With `ready` held at 1 and N = len+1: `ds` high E(1+W)..E(W+N), `done` E(W+N+1), `busy` low from E(W+N+2).
- Minimum turnaround: with WAIT_CYC=0 and len=0, go-to-done is 3 edges. A new `go` is accepted at the first edge in IDLE.
- `addr_o` equals the start address during CMD and WAIT and advances one per completed beat.

## Structure
- `mem_burst_pkg`: `state_e` enum (IDLE, CMD, WAIT, XFER, DONE).
- Single module, no sub-module. One shared down-counter, width max(LEN_W, $clog2(WAIT_CYC+1)), is reloaded for the wait phase and then the beat phase.

## Test plan
- Read, WAIT_CYC=2, len=3, addr_i=0x0010, `ready`=1 → `rd` 1 cycle, `ds` 4 cycles, `addr_o` 0x10→0x13, `done`=1 with `err`=0 at E7, `busy` low from E8.
- Write, len=0, WAIT_CYC=0 → `wr` E0–E1, `ds` one cycle, `done` at E2, `rd` never high.
- Same as test 1 with `ready` low 2 cycles mid-XFER → `ds` held high, `addr_o` frozen, `done` delayed exactly 2 cycles.
- `abort` during second wait cycle → `done`=1 and `err`=1 next cycle, `ds` never asserted; IDLE after.
- `addr_i`=0xFFFE, len=3 → `addr_o` 0xFFFE, 0xFFFF, 0x0000, 0x0001. `go` pulsed mid-burst → ignored.
- `rst_n` low mid-XFER → all outputs 0 immediately. After release, `go` restarts a normal burst.
